// File: rtl/rb_addr_gen_param.sv
// Row-buffer address generator: interleaves NUM_ROWS image rows across one dual-port BRAM,
// sequences a frame's pixel writes and column reads, and keeps unread rows from being overwritten.
module rb_addr_gen_param #(
    parameter int unsigned       NUM_ROWS  = 4,
    parameter int unsigned       ROW_LEN   = 512,
    parameter int unsigned       IMG_ROWS  = 512,
    parameter int unsigned       EXT_AW    = 32,
    parameter logic [EXT_AW-1:0] BASE_ADDR = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  wr_req,
    input  logic                                  rd_req,
    output logic                                  wr_ready,
    output logic                                  rd_ready,
    output logic [EXT_AW-1:0]                     e_mem_addr,
    output logic [$clog2(NUM_ROWS*ROW_LEN)-1:0]   w_bram_addr,
    output logic                                  w_bram_we,
    output logic [$clog2(ROW_LEN)-1:0]            r_bram_addr,
    output logic                                  r_bram_en,
    output logic [$clog2(NUM_ROWS)-1:0]           r_base_slot,
    output logic                                  row_done,
    output logic                                  frame_done,
    output logic                                  busy
);

    localparam int unsigned SLOT_W = $clog2(NUM_ROWS);
    localparam int unsigned COL_W  = $clog2(ROW_LEN);
    localparam int unsigned CNT_W  = $clog2(IMG_ROWS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0]  w_col;
    logic [COL_W-1:0]  r_col;
    logic [SLOT_W-1:0] wr_slot;
    logic [CNT_W-1:0]  rows_written;
    logic [CNT_W-1:0]  rows_read;
    logic [CNT_W-1:0]  diff;
    logic [EXT_AW-1:0] wcount;
    logic              rpass_active;

    logic active;
    logic wr_fire;
    logic rd_fire;
    logic w_last;
    logic r_last;
    logic final_pass;
    logic start_fire;

    // Flow control: the writer may enter the oldest slot only behind the reader's column.
    assign diff       = rows_written - rows_read;
    assign active     = (state != S_IDLE);
    assign w_last     = (w_col == COL_W'(ROW_LEN - 1));
    assign r_last     = (r_col == COL_W'(ROW_LEN - 1));
    assign wr_ready   = active && !abort && (rows_written < CNT_W'(IMG_ROWS)) &&
                        ((diff < CNT_W'(NUM_ROWS)) ||
                         ((diff == CNT_W'(NUM_ROWS)) && rpass_active && (w_col < r_col)));
    assign rd_ready   = active && !abort && (rpass_active || (diff == CNT_W'(NUM_ROWS)));
    assign wr_fire    = wr_req && wr_ready;
    assign rd_fire    = rd_req && rd_ready;
    assign final_pass = rd_fire && r_last && (rows_read == CNT_W'(IMG_ROWS - NUM_ROWS));
    assign start_fire = (state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (final_pass) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Write/read position counters; cleared at frame start and on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_col        <= '0;
            r_col        <= '0;
            wr_slot      <= '0;
            rows_written <= '0;
            rows_read    <= '0;
            wcount       <= '0;
            rpass_active <= 1'b0;
        end else if (abort || start_fire) begin
            w_col        <= '0;
            r_col        <= '0;
            wr_slot      <= '0;
            rows_written <= '0;
            rows_read    <= '0;
            wcount       <= '0;
            rpass_active <= 1'b0;
        end else begin
            if (wr_fire) begin
                wcount <= wcount + EXT_AW'(1);
                if (w_last) begin
                    w_col        <= '0;
                    wr_slot      <= wr_slot + SLOT_W'(1);
                    rows_written <= rows_written + CNT_W'(1);
                end else begin
                    w_col <= w_col + COL_W'(1);
                end
            end
            if (rd_fire) begin
                if (r_last) begin
                    r_col        <= '0;
                    rpass_active <= 1'b0;
                    rows_read    <= rows_read + CNT_W'(1);
                end else begin
                    r_col        <= r_col + COL_W'(1);
                    rpass_active <= 1'b1;
                end
            end
        end
    end

    // Registered BRAM/external-memory outputs; addresses hold when idle or aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_mem_addr  <= '0;
            w_bram_addr <= '0;
            w_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_en   <= 1'b0;
            r_base_slot <= '0;
            row_done    <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            w_bram_we  <= wr_fire;
            r_bram_en  <= rd_fire;
            row_done   <= rd_fire && r_last;
            frame_done <= final_pass;
            busy       <= (state_nxt != S_IDLE);
            if (wr_fire) begin
                w_bram_addr <= {w_col, wr_slot};
                e_mem_addr  <= BASE_ADDR + wcount;
            end
            if (rd_fire) begin
                r_bram_addr <= r_col;
                r_base_slot <= SLOT_W'(rows_read);
            end
        end
    end

endmodule

// File: tb/tb_rb_addr_gen_param.sv
// Bench for rb_addr_gen_param: scenario tasks plus a background scoreboard that predicts each
// strobe's addresses from the running write/read index since the last frame start.
module tb_rb_addr_gen_param;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned ROW_LEN  = 8;
    localparam int unsigned IMG_ROWS = 6;
    localparam int unsigned EXT_AW   = 32;
    localparam logic [31:0] BASE     = 32'h100;
    localparam int unsigned BA_W     = 5;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned SLOT_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              wr_req = 1'b0;
    logic              rd_req = 1'b0;
    logic              wr_ready;
    logic              rd_ready;
    logic [EXT_AW-1:0] e_mem_addr;
    logic [BA_W-1:0]   w_bram_addr;
    logic              w_bram_we;
    logic [COL_W-1:0]  r_bram_addr;
    logic              r_bram_en;
    logic [SLOT_W-1:0] r_base_slot;
    logic              row_done;
    logic              frame_done;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int wr_tot = 0;
    int rd_tot = 0;
    int wr_base = 0;
    int rd_base = 0;

    int unsigned exp_waddr_q[$];
    logic [31:0] exp_emem_q[$];
    int unsigned exp_raddr_q[$];
    int unsigned exp_slot_q[$];
    logic        exp_rdone_q[$];
    logic        exp_fdone_q[$];

    rb_addr_gen_param #(
        .NUM_ROWS (NUM_ROWS),
        .ROW_LEN  (ROW_LEN),
        .IMG_ROWS (IMG_ROWS),
        .EXT_AW   (EXT_AW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .wr_ready   (wr_ready),
        .rd_ready   (rd_ready),
        .e_mem_addr (e_mem_addr),
        .w_bram_addr(w_bram_addr),
        .w_bram_we  (w_bram_we),
        .r_bram_addr(r_bram_addr),
        .r_bram_en  (r_bram_en),
        .r_base_slot(r_base_slot),
        .row_done   (row_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Predicts at acceptance (2 before the edge), compares the strobes 1 after the edge.
    task automatic monitor();
        int          n;
        int unsigned col;
        int unsigned pass;
        int unsigned ea;
        logic [31:0] ee;
        int unsigned er;
        int unsigned es;
        logic        erd;
        logic        efd;
        forever begin
            @(negedge clk);
            #3;
            if (wr_req && wr_ready) begin
                n = wr_tot - wr_base;
                exp_waddr_q.push_back((n % ROW_LEN) * NUM_ROWS + (n / ROW_LEN) % NUM_ROWS);
                exp_emem_q.push_back(BASE + 32'(n));
                wr_tot++;
            end
            if (rd_req && rd_ready) begin
                n    = rd_tot - rd_base;
                col  = n % ROW_LEN;
                pass = n / ROW_LEN;
                exp_raddr_q.push_back(col);
                exp_slot_q.push_back(pass % NUM_ROWS);
                exp_rdone_q.push_back(col == ROW_LEN - 1);
                exp_fdone_q.push_back((col == ROW_LEN - 1) && (pass == IMG_ROWS - NUM_ROWS));
                rd_tot++;
            end
            #3;
            if (w_bram_we === 1'b1 || exp_waddr_q.size() != 0) begin
                checks++;
                if (exp_waddr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_write: unexpected w_bram_we addr=%0d e_mem_addr=%h", w_bram_addr, e_mem_addr);
                end else begin
                    ea = exp_waddr_q.pop_front();
                    ee = exp_emem_q.pop_front();
                    if (w_bram_we !== 1'b1 || w_bram_addr !== BA_W'(ea) || e_mem_addr !== ee) begin
                        errors++;
                        $display("FAIL sb_write: got we=%b addr=%0d e_mem_addr=%h, expected we=1 addr=%0d e_mem_addr=%h",
                                 w_bram_we, w_bram_addr, e_mem_addr, ea, ee);
                    end
                end
            end
            if (r_bram_en === 1'b1 || row_done === 1'b1 || frame_done === 1'b1 || exp_raddr_q.size() != 0) begin
                checks++;
                if (exp_raddr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_read: unexpected en=%b row_done=%b frame_done=%b", r_bram_en, row_done, frame_done);
                end else begin
                    er  = exp_raddr_q.pop_front();
                    es  = exp_slot_q.pop_front();
                    erd = exp_rdone_q.pop_front();
                    efd = exp_fdone_q.pop_front();
                    if (r_bram_en !== 1'b1 || r_bram_addr !== COL_W'(er) || r_base_slot !== SLOT_W'(es) ||
                        row_done !== erd || frame_done !== efd) begin
                        errors++;
                        $display("FAIL sb_read: got en=%b col=%0d slot=%0d rd=%b fd=%b, expected en=1 col=%0d slot=%0d rd=%b fd=%b",
                                 r_bram_en, r_bram_addr, r_base_slot, row_done, frame_done, er, es, erd, efd);
                    end
                end
            end
        end
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while ((wr_tot - wr_base) < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        if ((wr_tot - wr_base) < n) begin
            checks++;
            errors++;
            $display("FAIL wait_wr: got %0d writes, needed %0d", wr_tot - wr_base, n);
        end
    endtask

    task automatic wait_rd(input int n);
        int t = 0;
        while ((rd_tot - rd_base) < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        if ((rd_tot - rd_base) < n) begin
            checks++;
            errors++;
            $display("FAIL wait_rd: got %0d reads, needed %0d", rd_tot - rd_base, n);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start   = 1'b1;
        wr_base = wr_tot;
        rd_base = rd_tot;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [48:0] outs;
        @(negedge clk);
        #1;
        outs = {wr_ready, rd_ready, e_mem_addr, w_bram_addr, w_bram_we, r_bram_addr,
                r_bram_en, r_base_slot, row_done, frame_done, busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        wr_req = 1'b1;
        wait_wr(3);
        #2;
        checks++;
        if (w_bram_we !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: we=%b busy=%b expected 1 1", w_bram_we, busy);
        end
        rst_n  = 1'b0;
        wr_req = 1'b0;
        #1;
        outs = {wr_ready, rd_ready, e_mem_addr, w_bram_addr, w_bram_we, r_bram_addr,
                r_bram_en, r_base_slot, row_done, frame_done, busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        do_start();
        wr_req = 1'b1;
        rd_req = 1'b0;
        wait_wr(9);
        #2;
        checks++;
        if (w_bram_addr !== 5'd1 || e_mem_addr !== 32'h108) begin
            errors++;
            $display("FAIL fill_w9: addr=%0d emem=%h expected 1 108", w_bram_addr, e_mem_addr);
        end
        wait_wr(31);
        #2;
        checks++;
        if (rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_rd_early: rd_ready=%b expected 0", rd_ready);
        end
        wait_wr(32);
        #2;
        checks++;
        if (w_bram_addr !== 5'd31 || e_mem_addr !== 32'h11F || rd_ready !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_w32: addr=%0d emem=%h rd_ready=%b wr_ready=%b expected 31 11f 1 0",
                     w_bram_addr, e_mem_addr, rd_ready, wr_ready);
        end
    endtask

    task automatic test_stall();
        repeat (3) begin
            @(posedge clk);
            #2;
            checks++;
            if (wr_ready !== 1'b0 || w_bram_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_full: wr_ready=%b we=%b expected 0 0", wr_ready, w_bram_we);
            end
        end
        @(negedge clk);
        rd_req = 1'b1;
        wait_rd(1);
        #2;
        checks++;
        if (r_bram_en !== 1'b1 || r_bram_addr !== 3'd0 || r_base_slot !== 2'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_read1: en=%b col=%0d slot=%0d wr_ready=%b expected 1 0 0 1",
                     r_bram_en, r_bram_addr, r_base_slot, wr_ready);
        end
        @(negedge clk);
        rd_req = 1'b0;
        wait_wr(33);
        #2;
        checks++;
        if (w_bram_we !== 1'b1 || w_bram_addr !== 5'd0 || e_mem_addr !== 32'h120) begin
            errors++;
            $display("FAIL stall_w33: we=%b addr=%0d emem=%h expected 1 0 120", w_bram_we, w_bram_addr, e_mem_addr);
        end
        @(posedge clk);
        #2;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_trail: wr_ready=%b expected 0", wr_ready);
        end
    endtask

    task automatic test_concurrent();
        logic [COL_W-1:0] wc;
        int               lock_n = 0;
        @(negedge clk);
        rd_req = 1'b1;
        for (int cyc = 0; cyc < 300 && (rd_tot - rd_base) < 16; cyc++) begin
            @(posedge clk);
            #2;
            if (w_bram_we === 1'b1 && r_bram_en === 1'b1) begin
                wc = w_bram_addr[BA_W-1:SLOT_W] + COL_W'(1);
                lock_n++;
                checks++;
                if (r_bram_addr !== wc) begin
                    errors++;
                    $display("FAIL conc_trail: read col=%0d write col=%0d expected read = write+1",
                             r_bram_addr, w_bram_addr[BA_W-1:SLOT_W]);
                end
            end
        end
        checks++;
        if ((rd_tot - rd_base) < 16 || lock_n < 10) begin
            errors++;
            $display("FAIL conc_progress: reads=%0d lockstep=%0d expected 16 and >=10", rd_tot - rd_base, lock_n);
        end
    endtask

    task automatic test_frame_end();
        wait_rd(23);
        #2;
        checks++;
        if (wr_ready !== 1'b0 || (wr_tot - wr_base) != 48) begin
            errors++;
            $display("FAIL fend_writes: wr_ready=%b writes=%0d expected 0 48", wr_ready, wr_tot - wr_base);
        end
        wait_rd(24);
        #2;
        checks++;
        if (frame_done !== 1'b1 || row_done !== 1'b1 || busy !== 1'b1 || r_base_slot !== 2'd2) begin
            errors++;
            $display("FAIL fend_pulse: fd=%b rd=%b busy=%b slot=%0d expected 1 1 1 2",
                     frame_done, row_done, busy, r_base_slot);
        end
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || wr_ready !== 1'b0 || w_bram_we !== 1'b0) begin
            errors++;
            $display("FAIL fend_idle: busy=%b fd=%b wr_ready=%b we=%b expected 0 0 0 0",
                     busy, frame_done, wr_ready, w_bram_we);
        end
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic test_abort();
        do_start();
        wr_req = 1'b1;
        for (int cyc = 0; cyc < 400 && (rd_tot - rd_base) < 10; cyc++) begin
            @(negedge clk);
            rd_req = ((rd_tot - rd_base) < 10);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        abort  = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b0 || rd_ready !== 1'b0 || r_bram_en !== 1'b0 ||
            w_bram_we !== 1'b0 || r_bram_addr !== 3'd1 || r_base_slot !== 2'd1) begin
            errors++;
            $display("FAIL abort_idle: busy=%b wrr=%b rdr=%b en=%b we=%b col=%0d slot=%0d expected 0 0 0 0 0 1 1",
                     busy, wr_ready, rd_ready, r_bram_en, w_bram_we, r_bram_addr, r_base_slot);
        end
        @(negedge clk);
        abort = 1'b0;
        do_start();
        wr_req = 1'b1;
        wait_wr(1);
        #2;
        checks++;
        if (w_bram_we !== 1'b1 || w_bram_addr !== 5'd0 || e_mem_addr !== 32'h100 || rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: we=%b addr=%0d emem=%h rd_ready=%b expected 1 0 100 0",
                     w_bram_we, w_bram_addr, e_mem_addr, rd_ready);
        end
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_fill();
        test_stall();
        test_concurrent();
        test_frame_end();
        test_abort();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_waddr_q.size() != 0 || exp_raddr_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending writes=%0d reads=%0d expected 0 0",
                     exp_waddr_q.size(), exp_raddr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
